// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
`timescale 1ns/1ps
package ps2_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
    return ^{data, p};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Key-event handshake between the receiver FIFO head and the CPU I/O side.
`timescale 1ns/1ps
interface ps2_keyboard_rx_if;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       key_valid;
  logic       key_ack;

  modport master (output key_code, key_break, key_ext, key_valid, input key_ack);
  modport slave  (input key_code, key_break, key_ext, key_valid, output key_ack);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer with inter-edge timeout.
`timescale 1ns/1ps
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_strobe,
  output logic       o_frame_err
);

  localparam int TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam int FILT_W    = $clog2(FILTER_LEN + 1);

  logic [1:0]        r_clk_sync, r_dat_sync;
  logic [FILT_W-1:0] r_filt_cnt;
  logic              r_filt_clk, r_filt_clk_d;
  logic              w_fall, w_dat;
  ps2_state_t        r_state, w_state_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic              r_parity, w_parity_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic              r_err, w_err_nxt;

  assign w_dat         = r_dat_sync[1];
  assign w_fall        = r_filt_clk_d & ~r_filt_clk;
  assign o_byte        = r_shift;
  assign o_byte_strobe = r_strobe;
  assign o_frame_err   = r_err;

  // Synchronise both pins; filtered clock follows only a stable run of samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_filt_cnt   <= '0;
      r_filt_clk   <= 1'b1;
      r_filt_clk_d <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], i_ps2_dat};
      r_filt_clk_d <= r_filt_clk;
      if (r_clk_sync[1] == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        r_filt_cnt <= '0;
        r_filt_clk <= r_clk_sync[1];
      end else begin
        r_filt_cnt <= r_filt_cnt + FILT_W'(1);
      end
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_strobe  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_parity  <= w_parity_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_strobe  <= w_strobe_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state: advance on each filtered falling edge, abort on a stalled frame.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_parity_nxt  = r_parity;
    w_strobe_nxt  = 1'b0;
    w_err_nxt     = 1'b0;
    if ((r_state == IDLE) || w_fall) begin
      w_to_cnt_nxt = '0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + TO_W'(1);
    end
    if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_dat) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DATA: begin
          w_shift_nxt   = {w_dat, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end else begin
            w_state_nxt = DATA;
          end
        end
        PARITY: begin
          w_parity_nxt = w_dat;
          w_state_nxt  = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (w_dat && odd_parity_ok(r_shift, r_parity)) begin
            w_strobe_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if ((r_state != IDLE) && (r_to_cnt == TO_W'(TO_CYCLES - 1))) begin
      w_state_nxt  = IDLE;
      w_err_nxt    = 1'b1;
      w_to_cnt_nxt = '0;
    end else begin
      w_state_nxt = r_state;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame deframer, E0/F0 prefix folding and key-event FIFO.
`timescale 1ns/1ps
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      PS2_CLK,
  input  logic                      PS2_DAT,
  ps2_keyboard_rx_if.master         key_if,
  output logic                      rx_error,
  output logic                      overflow
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  key_event_t       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ext_pend, r_brk_pend, r_overflow;
  logic [7:0]       w_byte;
  logic             w_strobe, w_frame_err;
  logic             w_push_req, w_push, w_pop, w_full, w_empty;
  key_event_t       w_head, w_new;

  ps2_frame_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) u_frame_rx (
    .i_clk         (CLOCK_50),
    .i_rst         (reset),
    .i_ps2_clk     (PS2_CLK),
    .i_ps2_dat     (PS2_DAT),
    .o_byte        (w_byte),
    .o_byte_strobe (w_strobe),
    .o_frame_err   (w_frame_err)
  );

  assign w_push_req = w_strobe & (w_byte != PS2_PREFIX_EXT) & (w_byte != PS2_PREFIX_BREAK);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = key_if.key_ack & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_new      = {r_ext_pend, r_brk_pend, w_byte};
  assign w_head     = w_empty ? key_event_t'(10'h000) : r_mem[r_rd_ptr];

  assign key_if.key_code  = w_head.code;
  assign key_if.key_break = w_head.brk;
  assign key_if.key_ext   = w_head.ext;
  assign key_if.key_valid = ~w_empty;
  assign rx_error         = w_frame_err;
  assign overflow         = r_overflow;

  // Prefix flags accumulate until a real scan code consumes them.
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_frame_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_strobe) begin
      if (w_byte == PS2_PREFIX_EXT) begin
        r_ext_pend <= 1'b1;
      end else if (w_byte == PS2_PREFIX_BREAK) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
